// File: rtl/token_run_packer_if.sv
// Record handshake between token_run_packer and its consumer.
// master drives the record and valid; slave drives ready.
interface token_run_packer_if #(
  parameter int W = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_len;
  logic         out_tag;
  logic         out_sat;

  modport master (
    output out_valid,
    output out_len,
    output out_tag,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_len,
    input  out_tag,
    input  out_sat,
    output out_ready
  );
endinterface

// File: rtl/token_run_packer.sv
// Measures runs of consecutive 1 tokens on a and queues one length record per run.
// Define TOKEN_RUN_PACKER_ZERO_RUNS_EN to also report runs of zeros (tag=1).
module token_run_packer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a,
  token_run_packer_if.master  rec,
  output logic                drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt;
  logic         sat;
  logic         push;
  logic         push_tag;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W+1:0] mem [DEPTH];
  logic [W+1:0] head;
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

`ifdef TOKEN_RUN_PACKER_ZERO_RUNS_EN
  logic run_val;

  // A run ends when the token differs from the value being counted.
  always_comb begin
    push     = (cnt != '0) && (a != run_val);
    push_tag = ~run_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sat     <= 1'b0;
      run_val <= 1'b0;
    end else if (push || cnt == '0) begin
      cnt     <= W'(1);
      sat     <= 1'b0;
      run_val <= a;
    end else if (cnt == CNT_MAX) begin
      sat <= 1'b1;
    end else begin
      cnt <= cnt + W'(1);
    end
  end
`else
  always_comb begin
    push     = (cnt != '0) && !a;
    push_tag = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (a) begin
      if (cnt == CNT_MAX) sat <= 1'b1;
      else                cnt <= cnt + W'(1);
    end else begin
      cnt <= '0;
      sat <= 1'b0;
    end
  end
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && rec.out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (wr_en)                 wr_ptr <= wr_ptr + 1'b1;
      if (pop)                   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop)  drop   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_tag, sat, cnt};
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign rec.out_valid = !empty;
  assign rec.out_len   = empty ? '0   : head[W-1:0];
  assign rec.out_sat   = empty ? 1'b0 : head[W];
  assign rec.out_tag   = empty ? 1'b0 : head[W+1];
endmodule

// File: tb/tb_token_run_packer.sv
// Scoreboard bench for token_run_packer: stimulus queues expected records,
// a negedge monitor pops and compares whenever a record is handed off.
module tb_token_run_packer;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic drop;

  token_run_packer_if #(.W(W)) rec_if ();

  token_run_packer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .rec  (rec_if.master),
    .drop (drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] len;
    logic         tag;
    logic         sat;
  } rec_t;

  rec_t exp_q[$];
  rec_t head;
  int   tests  = 0;
  int   fails  = 0;
  int   popped = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [W-1:0] len, input logic tag, input logic sat);
    rec_t r;
    r.len = len;
    r.tag = tag;
    r.sat = sat;
    exp_q.push_back(r);
  endtask

  task automatic step(input logic v);
    a = v;
    @(posedge clk);
    #1;
  endtask

  // n ones then the terminating zero; optionally expect the record to be delivered
  task automatic ones_run(input int n, input bit logged, input logic [W-1:0] len, input logic sat);
    for (int i = 0; i < n; i++) step(1'b1);
    if (logged) exp_push(len, 1'b0, sat);
    step(1'b0);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step(1'b0);
    check("drain_timeout_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rec_if.out_valid) begin
        if (exp_q.size() == 0) begin
          if (rec_if.out_ready) begin
            tests++;
            fails++;
            $display("FAIL unexpected_record: got len %0d tag %0d sat %0d, required none",
                     rec_if.out_len, rec_if.out_tag, rec_if.out_sat);
          end
        end else begin
          head = exp_q[0];
          check("rec_len", rec_if.out_len, head.len);
          check("rec_tag", rec_if.out_tag, head.tag);
          check("rec_sat", rec_if.out_sat, head.sat);
          if (rec_if.out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end else begin
        check("empty_len", rec_if.out_len, 0);
        check("empty_tag", rec_if.out_tag, 0);
        check("empty_sat", rec_if.out_sat, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    rec_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", rec_if.out_valid, 0);
    check("reset_len",   rec_if.out_len,   0);
    check("reset_tag",   rec_if.out_tag,   0);
    check("reset_sat",   rec_if.out_sat,   0);
    check("reset_drop",  drop,             0);
    rst = 1'b0;

`ifdef TOKEN_RUN_PACKER_ZERO_RUNS_EN
    rec_if.out_ready = 1'b1;
    step(1'b0);
    step(1'b0);
    exp_push(8'd2, 1'b1, 1'b0);
    step(1'b1);
    check("zero_run_latency", rec_if.out_valid, 1);
    step(1'b1);
    step(1'b1);
    exp_push(8'd3, 1'b0, 1'b0);
    step(1'b0);
    drain(10);
    check("macro_count", popped, 2);
`else
    // basic run 0,1,1,1,0
    rec_if.out_ready = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    exp_push(8'd3, 1'b0, 1'b0);
    step(1'b0);
    check("basic_latency_valid", rec_if.out_valid, 1);
    drain(5);
    check("idle_zeros_valid", rec_if.out_valid, 0);

    // saturation, then a normal short run
    ones_run(300, 1'b1, 8'd255, 1'b1);
    drain(5);
    ones_run(2, 1'b1, 8'd2, 1'b0);
    drain(5);

    // back-pressure: the fifth record is discarded
    rec_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) ones_run(1, 1'b1, 8'd1, 1'b0);
    check("drop_before_fifth", drop, 0);
    ones_run(1, 1'b0, 8'd1, 1'b0);
    check("drop_after_fifth", drop, 1);
    base = popped;
    rec_if.out_ready = 1'b1;
    drain(10);
    repeat (3) step(1'b0);
    check("drop_drained_count", popped - base, 4);
    check("drop_sticky", drop, 1);
    check("drop_drained_valid", rec_if.out_valid, 0);

    // reset with a partial run and two records queued
    rec_if.out_ready = 1'b0;
    ones_run(1, 1'b0, 8'd1, 1'b0);
    ones_run(1, 1'b0, 8'd1, 1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("midreset_valid", rec_if.out_valid, 0);
    check("midreset_drop",  drop,             0);
    rec_if.out_ready = 1'b1;
    base = popped;
    ones_run(2, 1'b1, 8'd2, 1'b0);
    drain(5);
    repeat (2) step(1'b0);
    check("midreset_count", popped - base, 1);

    // push into a full FIFO on the same edge as a pop
    rec_if.out_ready = 1'b0;
    base = popped;
    ones_run(1, 1'b1, 8'd1, 1'b0);
    ones_run(2, 1'b1, 8'd2, 1'b0);
    ones_run(3, 1'b1, 8'd3, 1'b0);
    ones_run(1, 1'b1, 8'd1, 1'b0);
    step(1'b1);
    step(1'b1);
    exp_push(8'd2, 1'b0, 1'b0);
    rec_if.out_ready = 1'b1;
    step(1'b0);
    check("full_pop_no_drop", drop, 0);
    drain(10);
    repeat (2) step(1'b0);
    check("full_pop_count", popped - base, 5);
    check("full_pop_drop_final", drop, 0);
`endif

    check("scoreboard_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/token_run_packer.md
# token_run_packer

Serial-to-record stage that sits directly downstream of the token-doubling stage and consumes its serial token stream `b`. It measures each run of consecutive `1` tokens and emits one run-length record per run over a valid/ready interface. A small internal FIFO buffers records against downstream back-pressure. Lost records and oversized runs are flagged rather than silently mis-reported.

## Interface
- `W`, default 8: run-length field width; the counter saturates at 2^W-1.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  1  serial token stream, sampled every cycle.
- `out_valid`  out  1  FIFO head record available.
- `out_ready`  in  1  downstream accepts the head record.
- `out_len`  out  W  run length of the head record.
- `out_tag`  out  1  0 = run of ones, 1 = run of zeros (zeros only with the macro).
- `out_sat`  out  1  the run exceeded 2^W-1 tokens.
- `drop`  out  1  sticky: a record was discarded because the FIFO was full.

## Operation
- **Run counter.** Counts consecutive sampled `a`=1.
  - Saturates at 2^W-1.
  - A further 1 while saturated sets the run's sat bit.
- **Run termination.** A ones-run ends on the first sampled `a`=0 after at least one 1.
  - On that edge, record {tag=0, len=count, sat} is pushed.
  - The counter and sat bit clear.
- **Idle zeros.** Without the macro, consecutive zeros push nothing.
- **No flush.** An unterminated run is never emitted.
- **FIFO.** `DEPTH` entries, each holding {len, tag, sat}.
  - Pointers are log2(DEPTH)+1 bits wide. Empty means the pointers are equal. Full means the low bits are equal and the MSB differs.
- **Pop.** Occurs when `out_valid && out_ready`.
- **Push when full.**
  - Without a same-cycle pop, the record is discarded and `drop` sets on that edge.
  - With a same-cycle pop, the push succeeds and there is no drop.
- **Push when empty.** A same-cycle pop cannot occur, since `out_valid` is 0.
- **drop.** Stays high until `rst`.
  - FIFO operation continues normally while it is set.
- **Output stability.** While `out_valid && !out_ready`, `out_len`, `out_tag` and `out_sat` hold stable.
- **Empty outputs.** `out_len`, `out_tag` and `out_sat` read 0 whenever `out_valid`=0.
- **Reset.** Reset mid-run discards the partial run and all FIFO contents.

## Timing
- **Reset values.** `out_valid`=0, `out_len`=0, `out_tag`=0, `out_sat`=0, `drop`=0.
  - Counter and sat bit are 0; the FIFO is empty.
- **Latency.** Terminating token sampled at edge t gives `out_valid`=1 in the cycle after edge t, provided the FIFO was empty.
- **No bypass.** Outputs are driven from registered FIFO storage.
- **Throughput.**
  - Shortest ones-run pattern is `10`, giving at most one record every 2 cycles.
  - With the macro, records can arrive every cycle, e.g. `1010…`.
  - A full-rate `out_ready` never drops.
- **Output path.** `out_valid` depends only on FIFO pointers, with no combinational path from `out_ready`.

## Configuration
- **`TOKEN_RUN_PACKER_ZERO_RUNS_EN` defined.** Zero runs are also reported.
  - Zeros are counted by the same saturating counter.
  - A zeros-run ends on the first sampled 1 after at least one 0 and pushes {tag=1, len, sat}.
  - Zeros after reset form the first run.
  - Every token then belongs to exactly one emitted run, except the unterminated current run.
- **Macro undefined.** Only ones-runs are emitted and `out_tag` is tied to 0.

## Test plan
- **Basic run.** `a`=0,1,1,1,0 with `out_ready`=1 → one record len=3 tag=0 sat=0, valid in the cycle after the 0 is sampled.
- **Saturation, W=8.** 300 consecutive 1s then a 0 → len=255 sat=1; a following `110` → len=2 sat=0.
- **Back-pressure and drop, DEPTH=4.** `out_ready`=0, five `10` patterns → `drop`=1 after the fifth terminating 0.
  - Then `out_ready`=1 → exactly four records len=1, `drop` stays 1.
- **Simultaneous push/pop when full.** Fill 4 records, assert `out_ready`=1 on the terminating edge of a fifth run.
  - Expected: no drop, and all five records are delivered in order.
- **Reset mid-operation.** Pulse `rst` after `111` with 2 records queued → `out_valid`=0 and `drop`=0 next cycle.
  - A following `110` → a single len=2 record.
- **With macro.** `a`=0,0,1,1,1,0 after reset → records {tag=1, len=2} then {tag=0, len=3}.
